// File: rtl/mdu_iter_if.sv
// Register-file-side bus of the iterative multiply/divide unit: operation launch,
// MTHI/MTLO writes, and the architectural HI/LO plus status returned to the pipeline.
interface mdu_iter_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: sign-magnitude operands, one radix-2 step per
// cycle for WIDTH cycles, then a sign-fixup cycle that writes HI/LO.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  mdu_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state;
  logic                 op_div;
  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [5:0]           cnt;
  logic [2*WIDTH-1:0]   acc;

  logic                 is_signed;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       rem_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     a_orig;

  // acc is shared: {partial product high, multiplier} for multiply,
  // {remainder, dividend/quotient} for divide.
  always_comb begin
    is_signed = ~bus.op[0];
    abs_a     = (is_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    abs_b     = (is_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    rem_diff  = rem_shift - {1'b0, mag_b};
    prod_fix  = (sign_a ^ sign_b) ? -acc : acc;
    quo_fix   = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    a_orig    = sign_a ? -mag_a : mag_a;
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      op_div          <= 1'b0;
      sign_a          <= 1'b0;
      sign_b          <= 1'b0;
      mag_a           <= '0;
      mag_b           <= '0;
      cnt             <= '0;
      acc             <= '0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
    end else begin
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) bus.hi <= bus.wdata;
          if (bus.lo_we) bus.lo <= bus.wdata;
          if (bus.start) begin
            op_div <= bus.op[1];
            sign_a <= is_signed & bus.src_a[WIDTH-1];
            sign_b <= is_signed & bus.src_b[WIDTH-1];
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            cnt    <= '0;
            acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
            state  <= RUN;
          end
        end
        RUN: begin
          if (op_div) begin
            // Restoring step: keep the trial difference only when it did not borrow.
            if (!rem_diff[WIDTH]) acc <= {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  acc <= {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          bus.done <= 1'b1;
          if (op_div) begin
            if (mag_b == '0) begin
              bus.hi          <= a_orig;
              bus.lo          <= '1;
              bus.div_by_zero <= 1'b1;
            end else begin
              bus.hi <= rem_fix;
              bus.lo <= quo_fix;
            end
          end else begin
            bus.hi <= prod_fix[2*WIDTH-1:WIDTH];
            bus.lo <= prod_fix[WIDTH-1:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed MIPS corner cases plus randomized
// back-to-back operations checked against an arithmetic reference model.
module tb_mdu_iter;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(WIDTH)) bus ();
  mdu_iter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // Reference: full-width signed/unsigned arithmetic, C-style truncating division.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        want;
    longint      sa, sbv, q, r;
    logic [63:0] ua, ub, p;
    want = '0;
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    ua   = {32'b0, a};
    ub   = {32'b0, b};
    case (op)
      2'b00: begin p = 64'(sa * sbv); want.hi = p[63:32]; want.lo = p[31:0]; end
      2'b01: begin p = ua * ub;       want.hi = p[63:32]; want.lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          want.hi  = a;
          want.lo  = 32'hFFFF_FFFF;
          want.dbz = 1'b1;
        end else if (op == 2'b10) begin
          q = sa / sbv;
          r = sa % sbv;
          want.lo = q[31:0];
          want.hi = r[31:0];
        end else begin
          p = ua / ub; want.lo = p[31:0];
          p = ua % ub; want.hi = p[31:0];
        end
      end
    endcase
    return want;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (bus.busy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("issue_idle", 64'(bus.busy), 64'd0);
    if (bus.busy) return;
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic waitIdle();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 64'(bus.done), 64'd0);
      end else begin
        exp_t want;
        want = sb.pop_front();
        checkOutput("hi", 64'(bus.hi), 64'(want.hi));
        checkOutput("lo", 64'(bus.lo), 64'(want.lo));
        checkOutput("div_by_zero", 64'(bus.div_by_zero), 64'(want.dbz));
        last_hi = want.hi;
        last_lo = want.lo;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int done_at, done_cnt, busy_cnt, stray_dbz;
    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    checkOutput("rst_hi", 64'(bus.hi), 64'd0);
    checkOutput("rst_lo", 64'(bus.lo), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // MULT -1 x -1 with latency and busy-width measurement
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    done_at = 0; done_cnt = 0; busy_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
    end
    checkOutput("done_latency", 64'(done_at), 64'd34);
    checkOutput("busy_cycles", 64'(busy_cnt), 64'd33);
    checkOutput("done_width", 64'(done_cnt), 64'd1);

    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); waitIdle();
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0002); waitIdle();
    applyStimulus(2'b11, 32'h0000_0007, 32'h0000_0002); waitIdle();
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); waitIdle();

    applyStimulus(2'b11, 32'h0000_1234, 32'h0000_0000);
    stray_dbz = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.div_by_zero && !bus.done) stray_dbz++;
    end
    checkOutput("dbz_outside_done", 64'(stray_dbz), 64'd0);

    // MTLO then MTHI in IDLE, each visible one edge later
    @(posedge clk); #1;
    bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    checkOutput("mtlo", 64'(bus.lo), 64'hA5A5_A5A5);
    bus.hi_we = 1'b1; bus.wdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    checkOutput("mthi", 64'(bus.hi), 64'h5A5A_5A5A);
    checkOutput("mtlo_kept", 64'(bus.lo), 64'hA5A5_A5A5);
    applyStimulus(2'b00, 32'd3, 32'd4); waitIdle();

    // MTHI coincident with start lands first, then gets overwritten by FIX
    bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    applyStimulus(2'b01, 32'd5, 32'd7);
    bus.hi_we = 1'b0;
    checkOutput("mt_with_start", 64'(bus.hi), 64'hDEAD_BEEF);
    waitIdle();

    // start and hi_we pulsed mid-operation are ignored; HI/LO hold old result
    applyStimulus(2'b00, 32'hFFFF_0001, 32'h0001_2345);
    repeat (10) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd100; bus.src_b = 32'd3;
    bus.hi_we = 1'b1; bus.wdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0;
    checkOutput("hold_hi_run", 64'(bus.hi), 64'(last_hi));
    checkOutput("hold_lo_run", 64'(bus.lo), 64'(last_lo));
    waitIdle();
    repeat (40) @(posedge clk);
    #1;

    // Asynchronous reset at cycle 20 of a MULT abandons it
    applyStimulus(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
    checkOutput("midrst_hi", 64'(bus.hi), 64'd0);
    checkOutput("midrst_lo", 64'(bus.lo), 64'd0);
    sb.delete();
    last_hi = '0; last_lo = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    checkOutput("no_done_after_rst", 64'(done_cnt), 64'd0);

    // Randomized back-to-back issue: each start lands in the previous done cycle
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      applyStimulus(rop, ra, rb);
      repeat (33) @(posedge clk);
      #1;
    end
    waitIdle();

    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
